// File: rtl/ysyx_22041461_wb_csr.sv
// Write-back stage: GPR file with NRD combinational read ports plus a
// machine-mode CSR unit (Zicsr ops, ECALL/MRET, mcycle/minstret).
// Optional macro YSYX_22041461_WB_BYPASS_EN forwards the value being
// written this cycle onto matching GPR read ports.
module ysyx_22041461_wb_csr #(
  parameter int XLEN = 64,
  parameter int NRD  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [3:0]          wb_ctrl,
  input  logic [4:0]          wb_rd,
  input  logic [4:0]          wb_rs1,
  input  logic [11:0]         wb_csr,
  input  logic [XLEN-1:0]     wb_exe_in,
  input  logic [XLEN-1:0]     wb_mem_in,
  input  logic [XLEN-1:0]     wb_imm,
  input  logic [XLEN-1:0]     wb_pc,
  input  logic [4:0]          wb_zimm,
  input  logic [NRD*5-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [11:0]         csr_raddr,
  output logic [XLEN-1:0]     csr_rdata,
  output logic [XLEN-1:0]     mtvec_o,
  output logic [XLEN-1:0]     mepc_o,
  output logic                mie_o,
  output logic                retire,
  output logic                illegal_csr
);

`ifdef YSYX_22041461_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [3:0] OP_EXE = 4'd1, OP_MEM = 4'd2, OP_IMM = 4'd3, OP_SNPC = 4'd4;
  localparam logic [3:0] OP_RW = 4'd5, OP_RS = 4'd6, OP_RC = 4'd7;
  localparam logic [3:0] OP_RWI = 4'd8, OP_RSI = 4'd9, OP_RCI = 4'd10;
  localparam logic [3:0] OP_ECALL = 4'd11, OP_MRET = 4'd12;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MTVEC = 12'h305, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;

  // With XLEN=32 a counter write only replaces the low half.
  localparam logic [63:0] CNT_MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

  logic [XLEN-1:0] gpr [32];
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mepc, mcause, mscratch;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] mstatus_val;

  logic            is_csr, imm_form, src_zero, csr_legal, illegal, csr_we, gpr_we;
  logic [XLEN-1:0] src, csr_old, csr_wdata, gpr_wdata;

  function automatic logic csr_known(input logic [11:0] a);
    return (a == A_MSTATUS) || (a == A_MTVEC) || (a == A_MSCRATCH) || (a == A_MEPC) ||
           (a == A_MCAUSE) || (a == A_MCYCLE) || (a == A_MINSTRET);
  endfunction

  function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
    case (a)
      A_MSTATUS:  return mstatus_val;
      A_MTVEC:    return mtvec;
      A_MSCRATCH: return mscratch;
      A_MEPC:     return mepc;
      A_MCAUSE:   return mcause;
      A_MCYCLE:   return mcycle[XLEN-1:0];
      A_MINSTRET: return minstret[XLEN-1:0];
      default:    return '0;
    endcase
  endfunction

  // mstatus view: MPP hardwired to M, only MIE/MPIE stored.
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie;
    mstatus_val[3]     = mie;
  end

  // Decode the WB op into GPR / CSR write enables and data.
  always_comb begin
    is_csr    = (wb_ctrl >= OP_RW) && (wb_ctrl <= OP_RCI);
    imm_form  = (wb_ctrl >= OP_RWI) && (wb_ctrl <= OP_RCI);
    src       = imm_form ? XLEN'(wb_zimm) : ((wb_rs1 == 5'd0) ? '0 : gpr[wb_rs1]);
    src_zero  = imm_form ? (wb_zimm == 5'd0) : (wb_rs1 == 5'd0);
    csr_old   = csr_value(wb_csr);
    csr_legal = csr_known(wb_csr);
    illegal   = wb_valid && is_csr && !csr_legal;
    csr_we    = wb_valid && is_csr && csr_legal &&
                ((wb_ctrl == OP_RW) || (wb_ctrl == OP_RWI) || !src_zero);
    csr_wdata = '0;
    case (wb_ctrl)
      OP_RW, OP_RWI: csr_wdata = src;
      OP_RS, OP_RSI: csr_wdata = csr_old | src;
      OP_RC, OP_RCI: csr_wdata = csr_old & ~src;
      default:       csr_wdata = '0;
    endcase
    gpr_wdata = '0;
    gpr_we    = 1'b0;
    case (wb_ctrl)
      OP_EXE:  begin gpr_we = 1'b1; gpr_wdata = wb_exe_in; end
      OP_MEM:  begin gpr_we = 1'b1; gpr_wdata = wb_mem_in; end
      OP_IMM:  begin gpr_we = 1'b1; gpr_wdata = wb_imm; end
      OP_SNPC: begin gpr_we = 1'b1; gpr_wdata = wb_pc + XLEN'(4); end
      default: begin gpr_we = is_csr && csr_legal; gpr_wdata = csr_old; end
    endcase
    gpr_we = gpr_we && wb_valid && (wb_rd != 5'd0);
  end

  // Architectural state update; counters tick every cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      mie         <= 1'b0;
      mpie        <= 1'b0;
      mtvec       <= '0;
      mepc        <= '0;
      mcause      <= '0;
      mscratch    <= '0;
      mcycle      <= '0;
      minstret    <= '0;
      retire      <= 1'b0;
      illegal_csr <= 1'b0;
    end else begin
      retire      <= wb_valid && !illegal;
      illegal_csr <= illegal;
      if (gpr_we) gpr[wb_rd] <= gpr_wdata;
      if (csr_we) begin
        case (wb_csr)
          A_MSTATUS:  begin mie <= csr_wdata[3]; mpie <= csr_wdata[7]; end
          A_MTVEC:    mtvec <= {csr_wdata[XLEN-1:2], 2'b00};
          A_MSCRATCH: mscratch <= csr_wdata;
          A_MEPC:     mepc <= {csr_wdata[XLEN-1:2], 2'b00};
          A_MCAUSE:   mcause <= csr_wdata;
          default:    ;
        endcase
      end
      if (wb_valid && wb_ctrl == OP_ECALL) begin
        mepc   <= {wb_pc[XLEN-1:2], 2'b00};
        mcause <= XLEN'(11);
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (wb_valid && wb_ctrl == OP_MRET) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
      if (csr_we && wb_csr == A_MCYCLE)
        mcycle <= (mcycle & ~CNT_MASK) | (64'(csr_wdata) & CNT_MASK);
      else
        mcycle <= mcycle + 64'd1;
      if (csr_we && wb_csr == A_MINSTRET)
        minstret <= (minstret & ~CNT_MASK) | (64'(csr_wdata) & CNT_MASK);
      else if (wb_valid && !illegal)
        minstret <= minstret + 64'd1;
    end
  end

  // GPR read ports, optionally forwarding the in-flight write.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (BYPASS && !rst && gpr_we && rd_addr[k*5 +: 5] == wb_rd)
        rd_data[k*XLEN +: XLEN] = gpr_wdata;
      else if (rd_addr[k*5 +: 5] != 5'd0)
        rd_data[k*XLEN +: XLEN] = gpr[rd_addr[k*5 +: 5]];
    end
  end

  // Side-band CSR read port and trap outputs, never bypassed.
  always_comb begin
    csr_rdata = csr_value(csr_raddr);
    mtvec_o   = mtvec;
    mepc_o    = mepc;
    mie_o     = mie;
  end

endmodule

// File: tb/tb_ysyx_22041461_wb_csr.sv
// Directed bench for ysyx_22041461_wb_csr (XLEN=64, NRD=5).
module tb_ysyx_22041461_wb_csr;
  localparam int XLEN = 64;
  localparam int NRD  = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                wb_valid;
  logic [3:0]          wb_ctrl;
  logic [4:0]          wb_rd, wb_rs1, wb_zimm;
  logic [11:0]         wb_csr, csr_raddr;
  logic [XLEN-1:0]     wb_exe_in, wb_mem_in, wb_imm, wb_pc;
  logic [NRD*5-1:0]    rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [XLEN-1:0]     csr_rdata, mtvec_o, mepc_o;
  logic                mie_o, retire, illegal_csr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic  ret;
    logic  ill;
  } exp_t;
  exp_t exp_q[$];

  ysyx_22041461_wb_csr #(.XLEN(XLEN), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
    .wb_rs1(wb_rs1), .wb_csr(wb_csr), .wb_exe_in(wb_exe_in), .wb_mem_in(wb_mem_in),
    .wb_imm(wb_imm), .wb_pc(wb_pc), .wb_zimm(wb_zimm), .rd_addr(rd_addr),
    .rd_data(rd_data), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o), .retire(retire),
    .illegal_csr(illegal_csr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_op(input string tag, input logic v, input logic [3:0] ctrl,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] csr,
                          input logic [63:0] data, input logic [63:0] pc, input logic [4:0] zimm,
                          input logic eret, input logic eill);
    wb_valid  = v;
    wb_ctrl   = ctrl;
    wb_rd     = rd;
    wb_rs1    = rs1;
    wb_csr    = csr;
    wb_exe_in = data;
    wb_mem_in = data + 64'd1;
    wb_imm    = data + 64'd2;
    wb_pc     = pc;
    wb_zimm   = zimm;
    exp_q.push_back('{tag: tag, ret: eret, ill: eill});
  endtask

  task automatic finish_op();
    exp_t e;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    wb_ctrl  = 4'd0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_retire"}, {63'd0, retire}, {63'd0, e.ret});
      chk({e.tag, "_illegal"}, {63'd0, illegal_csr}, {63'd0, e.ill});
    end
  endtask

  task automatic op(input string tag, input logic [3:0] ctrl, input logic [4:0] rd,
                    input logic [4:0] rs1, input logic [11:0] csr, input logic [63:0] data,
                    input logic [63:0] pc, input logic [4:0] zimm, input logic eret,
                    input logic eill);
    drive_op(tag, 1'b1, ctrl, rd, rs1, csr, data, pc, zimm, eret, eill);
    finish_op();
  endtask

  task automatic gpr(input string tag, input int port, input logic [4:0] a, input logic [63:0] expv);
    rd_addr = '0;
    rd_addr[port*5 +: 5] = a;
    #1;
    chk(tag, rd_data[port*XLEN +: XLEN], expv);
  endtask

  task automatic csr(input string tag, input logic [11:0] a, input logic [63:0] expv);
    csr_raddr = a;
    #1;
    chk(tag, csr_rdata, expv);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_ctrl = 4'd0; wb_rd = 5'd0; wb_rs1 = 5'd0;
    wb_csr = 12'd0; wb_exe_in = '0; wb_mem_in = '0; wb_imm = '0; wb_pc = '0;
    wb_zimm = 5'd0; rd_addr = '0; csr_raddr = 12'd0;
    idle();
    idle();
    rst = 1'b0;

    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_illegal", {63'd0, illegal_csr}, 64'd0);
    chk("rst_rd_data", rd_data[63:0], 64'd0);
    chk("rst_mtvec", mtvec_o, 64'd0);
    chk("rst_mie", {63'd0, mie_o}, 64'd0);
    csr("rst_mstatus", 12'h300, 64'h1800);

    for (int i = 0; i < 10; i++) idle();

    // First EXE: check the same-cycle read before the edge.
    drive_op("exe_x5", 1'b1, 4'd1, 5'd5, 5'd0, 12'd0, 64'h1234, 64'd0, 5'd0, 1'b1, 1'b0);
    rd_addr = '0;
    rd_addr[4:0] = 5'd5;
    #1;
`ifdef YSYX_22041461_WB_BYPASS_EN
    chk("same_cycle_x5", rd_data[63:0], 64'h1234);
`else
    chk("same_cycle_x5", rd_data[63:0], 64'h0);
`endif
    finish_op();
    op("exe_x0", 4'd1, 5'd0, 5'd0, 12'd0, 64'hFFFF, 64'd0, 5'd0, 1'b1, 1'b0);
    op("exe_x6", 4'd1, 5'd6, 5'd0, 12'd0, 64'h55, 64'd0, 5'd0, 1'b1, 1'b0);
    gpr("x5", 0, 5'd5, 64'h1234);
    gpr("x0", 0, 5'd0, 64'h0);
    gpr("x6_port4", 4, 5'd6, 64'h55);
    csr("mcycle_13", 12'hB00, 64'd13);
    csr("minstret_3", 12'hB02, 64'd3);

    op("csrrw_minstret", 4'd5, 5'd0, 5'd0, 12'hB02, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    csr("minstret_0", 12'hB02, 64'd0);
    csr("mcycle_14", 12'hB00, 64'd14);

    op("exe_x1", 4'd1, 5'd1, 5'd0, 12'd0, 64'h8000_0003, 64'd0, 5'd0, 1'b1, 1'b0);
    op("csrrw_mtvec", 4'd5, 5'd2, 5'd1, 12'h305, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    chk("mtvec_o", mtvec_o, 64'h8000_0000);
    gpr("x2_old_mtvec", 1, 5'd2, 64'd0);

    op("csrrsi_mstatus", 4'd9, 5'd7, 5'd0, 12'h300, 64'd0, 64'd0, 5'd8, 1'b1, 1'b0);
    chk("mie_set", {63'd0, mie_o}, 64'd1);
    gpr("x7_old_mstatus", 0, 5'd7, 64'h1800);
    csr("mstatus_mie", 12'h300, 64'h1808);

    op("ecall", 4'd11, 5'd0, 5'd0, 12'd0, 64'd0, 64'h8000_0100, 5'd0, 1'b1, 1'b0);
    chk("mepc_o", mepc_o, 64'h8000_0100);
    csr("mcause", 12'h342, 64'd11);
    chk("ecall_mie", {63'd0, mie_o}, 64'd0);
    csr("ecall_mstatus", 12'h300, 64'h1880);

    op("mret", 4'd12, 5'd0, 5'd0, 12'd0, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    chk("mret_mie", {63'd0, mie_o}, 64'd1);
    csr("mret_mstatus", 12'h300, 64'h1888);

    op("illegal", 4'd5, 5'd3, 5'd1, 12'h7C0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
    gpr("x3_unchanged", 2, 5'd3, 64'd0);
    chk("illegal_mtvec", mtvec_o, 64'h8000_0000);
    csr("illegal_mstatus", 12'h300, 64'h1888);
    csr("unknown_read", 12'h7C0, 64'd0);

    op("snpc_wrap", 4'd4, 5'd8, 5'd0, 12'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0, 1'b1, 1'b0);
    gpr("x8_snpc", 3, 5'd8, 64'd2);
    op("mem_x12", 4'd2, 5'd12, 5'd0, 12'd0, 64'h100, 64'd0, 5'd0, 1'b1, 1'b0);
    gpr("x12_mem", 0, 5'd12, 64'h101);
    op("imm_x13", 4'd3, 5'd13, 5'd0, 12'd0, 64'h200, 64'd0, 5'd0, 1'b1, 1'b0);
    gpr("x13_imm", 0, 5'd13, 64'h202);

    op("csrrw_mscratch", 4'd5, 5'd0, 5'd6, 12'h340, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    op("csrrc_rs1_0", 4'd7, 5'd9, 5'd0, 12'h340, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    gpr("x9_mscratch", 0, 5'd9, 64'h55);
    csr("mscratch_kept", 12'h340, 64'h55);
    op("csrrci", 4'd10, 5'd10, 5'd0, 12'h340, 64'd0, 64'd0, 5'd1, 1'b1, 1'b0);
    gpr("x10_mscratch", 0, 5'd10, 64'h55);
    csr("mscratch_cleared", 12'h340, 64'h54);

    op("nop13", 4'd13, 5'd4, 5'd0, 12'd0, 64'h77, 64'd0, 5'd0, 1'b1, 1'b0);
    gpr("x4_nop", 0, 5'd4, 64'd0);
    drive_op("not_valid", 1'b0, 4'd1, 5'd14, 5'd0, 12'd0, 64'h9, 64'd0, 5'd0, 1'b0, 1'b0);
    finish_op();
    gpr("x14_not_valid", 0, 5'd14, 64'd0);

    drive_op("rst_wins", 1'b1, 4'd1, 5'd11, 5'd0, 12'd0, 64'h7, 64'd0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    finish_op();
    rst = 1'b0;
    gpr("x11_after_rst", 0, 5'd11, 64'd0);
    chk("mtvec_after_rst", mtvec_o, 64'd0);
    csr("minstret_after_rst", 12'hB02, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22041461_wb_csr.md
# ysyx_22041461_wb_csr

Parametrised write-back stage: general-purpose register file with NRD combinational read ports, plus a machine-mode CSR unit (Zicsr read-modify-write ops, ECALL/MRET trap state, mcycle/minstret counters). It sits at the end of the pipeline and serves ID/EXE/MEM operand reads and the trap PC targets for ID. Illegal CSR accesses are flagged to the core, not halted on.

## Interface
- XLEN, 64, data width; 32 or 64 only
- NRD, 5, number of GPR read ports
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  instruction in WB this cycle
- wb_ctrl  in  4  op: 0 NOP, 1 EXE, 2 MEM, 3 IMM, 4 SNPC, 5 CSRRW, 6 CSRRS, 7 CSRRC, 8 CSRRWI, 9 CSRRSI, 10 CSRRCI, 11 ECALL, 12 MRET, 13-15 NOP
- wb_rd, wb_rs1  in  5  destination / CSR source register
- wb_csr  in  12  CSR address
- wb_exe_in, wb_mem_in, wb_imm, wb_pc  in  XLEN  result sources
- wb_zimm  in  5  CSR immediate, zero-extended
- rd_addr  in  NRD*5  packed read addresses, port k at [5k+4:5k]
- rd_data  out  NRD*XLEN  packed read data
- csr_raddr  in  12  / csr_rdata  out  XLEN  combinational CSR read port
- mtvec_o, mepc_o  out  XLEN  current mtvec / mepc
- mie_o  out  1  mstatus.MIE
- retire  out  1  registered pulse, one instruction retired
- illegal_csr  out  1  registered pulse, unknown CSR address

## Operation
- GPR: x0 reads 0, writes to x0 discarded. EXE/MEM/IMM write wb_exe_in/wb_mem_in/wb_imm; SNPC writes wb_pc+4 (modulo 2^XLEN).
- CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02. Other address = illegal.
- CSR ops: rd <= old CSR; source s = x[rs1] (pre-write) or zext(zimm). RW: csr<=s; RS: csr<=old|s; RC: csr<=old&~s. RS/RC/RSI/RCI with rs1/zimm = 0 perform no CSR write.
- Write masks: mtvec, mepc bits[1:0] forced 0; mstatus writable MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other mstatus bits read 0; mcause fully writable.
- ECALL: mepc<=wb_pc, mcause<=11, MPIE<=MIE, MIE<=0. MRET: MIE<=MPIE, MPIE<=1. No GPR write.
- Illegal CSR: no GPR/CSR update, illegal_csr=1 next cycle, retire=0.
- Counters are 64-bit; mcycle +1 every cycle out of reset; minstret +1 per retire. CSR write to a counter overrides that cycle's increment. With XLEN=32 only low 32 bits accessible (0xB80/0xB82 not implemented, illegal).
- csr_rdata returns masked current value, 0 for unknown addresses.

## Timing
- Writes commit at the rising edge where wb_valid=1; reads see them from the next cycle (see Configuration).
- retire: 1 the cycle after any valid non-illegal op, including NOP codes.
- Reset: all GPRs, mtvec, mepc, mcause, mscratch, counters = 0; mstatus reads 0x1800; retire=illegal_csr=0; rd_data=0.
- rst wins over wb_valid in the same cycle; instruction dropped, not retired.
- wb_valid=0: no state change except mcycle.
- Throughput one instruction per cycle; no back-pressure.

## Configuration
- YSYX_22041461_WB_BYPASS_EN defined: rd_data port k returns the value being written this cycle when wb_valid, the op writes a GPR, wb_rd!=0 and rd_addr k == wb_rd (CSR ops bypass old CSR value). csr_rdata is never bypassed.
- Undefined: rd_data always returns registered state; consumers see writes one cycle later.

## Test plan
- Reset, then EXE rd=5 data 0x1234 -> next cycle rd_data port0 (addr 5)=0x1234, retire=1; same-cycle read = 0x1234 with BYPASS_EN, 0 without.
- EXE rd=0 data 0xFFFF -> x0 still reads 0, retire=1.
- x1=0x80000003, CSRRW mtvec rd=2 rs1=1 -> mtvec_o=0x80000000, x2=0; CSRRSI mstatus zimm=8 -> mie_o=1.
- mie=1, ECALL pc=0x80000100 -> mepc_o=0x80000100, mcause=11, mie_o=0, MPIE=1; MRET -> mie_o=1.
- CSRRW csr 0x7C0 rd=3 -> illegal_csr=1, retire=0, x3 and all CSRs unchanged.
- 10 idle cycles after reset then 3 EXE ops -> mcycle=13, minstret=3; CSRRW minstret<-0 -> minstret reads 0 next cycle.
